// File: rtl/cgen_memory_rd_port_ctrl.sv
// Read-port controller: issues reads to one port of a multi-read memory and returns
// the results in request order through a show-ahead response FIFO sized by DEPTH.
`ifndef CGEN_LOG2
`define CGEN_LOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module cgen_memory_rd_port_ctrl #(
  parameter  int BITS    = 4,
  parameter  int SIZE    = 128,
  parameter  int LATENCY = 2,
  parameter  int DEPTH   = 4,
  localparam int AW      = `CGEN_LOG2(SIZE)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BITS-1:0] rsp_data,
  output logic [AW-1:0]   rd_addr,
  output logic            rd_enable,
  input  logic [BITS-1:0] rd_dout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = `CGEN_LOG2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [CW-1:0]      used;
  logic [CW-1:0]      used_nxt;
  logic               ready_q;
  logic [LATENCY-1:0] vld_pipe;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic [CW-1:0]      fifo_cnt_nxt;
  logic [BITS-1:0]    fifo_mem [DEPTH];

  logic issue;
  logic pop;
  logic fifo_wr;

  assign issue     = req_valid && ready_q;
  assign pop       = rsp_valid && rsp_ready;
  assign fifo_wr   = vld_pipe[LATENCY-1];

  assign req_ready = ready_q;
  assign rd_enable = issue;
  assign rd_addr   = req_addr;
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = fifo_mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // used covers in-flight reads as well as buffered words, so it alone gates issue
  always_comb begin
    used_nxt = used;
    if (issue && !pop) begin
      used_nxt = used + CW'(1);
    end else if (!issue && pop) begin
      used_nxt = used - CW'(1);
    end
  end

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (fifo_wr && !pop) begin
      fifo_cnt_nxt = fifo_cnt + CW'(1);
    end else if (!fifo_wr && pop) begin
      fifo_cnt_nxt = fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      used     <= '0;
      ready_q  <= 1'b0;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      used        <= used_nxt;
      ready_q     <= (used_nxt < DEPTH_C);
      vld_pipe[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
      fifo_cnt <= fifo_cnt_nxt;
      if (fifo_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Storage is captured only behind a valid last stage; the memory drives X otherwise
  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= rd_dout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(fifo_wr && (fifo_cnt == DEPTH_C)))
        else $error("response FIFO written while full");
      assert (used <= DEPTH_C)
        else $error("occupancy counter exceeded DEPTH");
    end
  end

endmodule

// File: tb/tb_cgen_memory_rd_port_ctrl.sv
// Bench for cgen_memory_rd_port_ctrl with a two-cycle memory model (mem[a] = a + 8'h10)
// and an in-order scoreboard fed by accepted requests.
module tb_cgen_memory_rd_port_ctrl;

  localparam int BITS    = 8;
  localparam int SIZE    = 128;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int AW      = 7;

  logic            clock;
  logic            reset_n;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic [AW-1:0]   rd_addr;
  logic            rd_enable;
  logic [BITS-1:0] rd_dout;

  int errors = 0;
  int checks = 0;
  int rsp_total = 0;

  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] sb_exp;
  int              sb_size;

  cgen_memory_rd_port_ctrl #(
    .BITS(BITS), .SIZE(SIZE), .LATENCY(LATENCY), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_dout(rd_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // two-cycle read: address registered, then data registered; X when nothing was read
  logic [AW-1:0] mem_a_q;
  logic          mem_en_q;
  always @(posedge clock) begin
    mem_a_q  <= rd_addr;
    mem_en_q <= rd_enable;
    rd_dout  <= mem_en_q ? (8'h10 + {1'b0, mem_a_q}) : 'x;
  end

  // scoreboard: push on accept, pop and compare on every consumed response
  always @(negedge clock) begin
    if (reset_n) begin
      sb_size = exp_q.size();
      if (rsp_valid && rsp_ready) begin
        checks++;
        rsp_total++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: got %h, required no response", rsp_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if (rsp_data !== sb_exp) begin
            errors++;
            $display("FAIL sb_order: rsp_data=%h, required %h", rsp_data, sb_exp);
          end
        end
      end
      if (req_valid && req_ready) begin
        checks++;
        if (sb_size >= DEPTH) begin
          errors++;
          $display("FAIL sb_used_bound: accepted with %0d outstanding, required < %0d", sb_size, DEPTH);
        end
        exp_q.push_back(8'h10 + {1'b0, req_addr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finished", $time);
    $fatal(1);
  end

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_addr = 7'd3; rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rd_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_enable: got %b, required 0", rd_enable); end
    @(posedge clock); #1;
    req_valid = 1'b0; reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b, required 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_idle: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_single();
    logic exp_en;
    logic exp_v;
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      req_valid = (c == 0); req_addr = 7'd5; rsp_ready = 1'b1;
      @(negedge clock);
      exp_en = (c == 0);
      exp_v  = (c == 3);
      checks++; if (rd_enable !== exp_en) begin errors++; $display("FAIL single_rd_enable c%0d: got %b, required %b", c, rd_enable, exp_en); end
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL single_rsp_valid c%0d: got %b, required %b", c, rsp_valid, exp_v); end
      if (c == 0) begin
        checks++; if (rd_addr !== 7'd5) begin errors++; $display("FAIL single_rd_addr: got %0d, required 5", rd_addr); end
      end
      if (c == 3) begin
        checks++; if (rsp_data !== 8'h15) begin errors++; $display("FAIL single_rsp_data: got %h, required 15", rsp_data); end
      end
    end
  endtask

  task automatic test_stream();
    logic            exp_v;
    logic [BITS-1:0] exp_d;
    for (int c = 0; c < 13; c++) begin
      @(posedge clock); #1;
      req_valid = (c < 8); req_addr = 7'(c); rsp_ready = 1'b1;
      @(negedge clock);
      if (c < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_req_ready c%0d: got %b, required 1", c, req_ready); end
      end
      exp_v = (c >= 3) && (c <= 10);
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL stream_rsp_valid c%0d: got %b, required %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        exp_d = 8'(8'h10 + c - 3);
        checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL stream_rsp_data c%0d: got %h, required %h", c, rsp_data, exp_d); end
      end
    end
  endtask

  task automatic test_backpressure();
    int   next_a = 1;
    logic exp_r;
    for (int c = 0; c < 14; c++) begin
      @(posedge clock); #1;
      req_valid = (next_a <= 5); req_addr = 7'(next_a); rsp_ready = (c >= 8);
      @(negedge clock);
      if (c <= 9) begin
        exp_r = (c < 4) || (c == 9);
        checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL bp_req_ready c%0d: got %b, required %b", c, req_ready, exp_r); end
      end
      if (c >= 3 && c <= 8) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin errors++; $display("FAIL bp_head_hold c%0d: got v=%b d=%h, required v=1 d=11", c, rsp_valid, rsp_data); end
      end
      if (c == 9) begin
        checks++; if (rd_enable !== 1'b1 || rd_addr !== 7'd5) begin errors++; $display("FAIL bp_addr5_issue: got en=%b a=%0d, required en=1 a=5", rd_enable, rd_addr); end
      end
      if (c == 11) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h14) begin errors++; $display("FAIL bp_rsp_14: got v=%b d=%h, required v=1 d=14", rsp_valid, rsp_data); end
      end
      if (c == 12) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h15) begin errors++; $display("FAIL bp_rsp_15: got v=%b d=%h, required v=1 d=15", rsp_valid, rsp_data); end
      end
      if (c == 13) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b, required 0", rsp_valid); end
      end
      if (req_valid && req_ready) next_a++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int              sent = 0;
    int              start;
    bit              done = 0;
    logic            hold = 1'b0;
    logic [BITS-1:0] held = '0;
    start = rsp_total;
    for (int c = 0; c < 80; c++) begin
      @(posedge clock); #1;
      if (sent == 12 && rsp_total == start + 12) begin
        done = 1;
        break;
      end
      req_valid = (sent < 12); req_addr = 7'(40 + sent * 3); rsp_ready = (c % 2 == 0);
      @(negedge clock);
      if (hold) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== held) begin errors++; $display("FAIL wrap_hold c%0d: got v=%b d=%h, required v=1 d=%h", c, rsp_valid, rsp_data, held); end
      end
      hold = rsp_valid && !rsp_ready;
      held = rsp_data;
      if (req_valid && req_ready) sent++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout: sent=%0d rsp=%0d, required 12 and 12", sent, rsp_total - start); end
    checks++; if (rsp_total - start != 12) begin errors++; $display("FAIL wrap_count: got %0d responses, required 12", rsp_total - start); end
  endtask

  task automatic test_reset_midflight();
    int   start;
    logic exp_v;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      req_valid = 1'b1; req_addr = 7'(2 + c); rsp_ready = 1'b1;
      @(negedge clock);
    end
    @(posedge clock); #1;
    req_valid = 1'b0; reset_n = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got r=%b v=%b, required 0 0", req_ready, rsp_valid); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    start = rsp_total;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rsp c%0d: got v=%b d=%h, required v=0", c, rsp_valid, rsp_data); end
    end
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      req_valid = (c == 0); req_addr = 7'd9;
      @(negedge clock);
      exp_v = (c == 3);
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL mid_new_valid c%0d: got %b, required %b", c, rsp_valid, exp_v); end
      if (c == 3) begin
        checks++; if (rsp_data !== 8'h19) begin errors++; $display("FAIL mid_new_data: got %h, required 19", rsp_data); end
      end
    end
    @(posedge clock); #1;
    checks++; if (rsp_total - start != 1) begin errors++; $display("FAIL mid_rsp_count: got %0d, required 1", rsp_total - start); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d expected responses outstanding, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
